burst_rr_arbiter: RTL

Round-robin arbiter that gives one of `CLIENTS` requesters exclusive ownership of a shared resource for a multi-beat burst. Ownership is held until the owner marks its final beat, drops its request, or hits the `MAX_HOLD` beat limit. Arbitration is registered, and ownership passes back-to-back with no idle cycle. It sits in front of any shared datapath whose transfers span several cycles and cannot be interleaved.

---
 rtl/burst_arb_pkg.sv | 9 +
 rtl/burst_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/burst_rr_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/burst_arb_pkg.sv
// Shared types for the burst round-robin arbiter.
package burst_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/burst_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr, wrapping.
import burst_arb_pkg::*;

module rr_pick #(
  parameter int CLIENTS   = 8,
  parameter int CLIENTS_W = $clog2(CLIENTS)
) (
  input  logic [CLIENTS-1:0]   req,
  input  logic [CLIENTS_W-1:0] ptr,
  output logic                 valid,
  output logic [CLIENTS_W-1:0] idx,
  output logic [CLIENTS-1:0]   onehot
);

  localparam int DW = $clog2(2 * CLIENTS);

  logic [2*CLIENTS-1:0] dbl;
  logic [CLIENTS-1:0]   rot;
  logic [DW-1:0]        sel;

  // Two copies of req side by side let ptr+1..ptr+CLIENTS be read without wrapping.
  always_comb begin
    dbl    = {req, req};
    rot    = '0;
    sel    = '0;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int unsigned j = 0; j < CLIENTS; j++) begin
      rot[j] = dbl[DW'(ptr) + DW'(j) + DW'(1)];
    end
    for (int unsigned j = 0; j < CLIENTS; j++) begin
      if (!valid && rot[j]) begin
        valid = 1'b1;
        sel   = DW'(ptr) + DW'(j) + DW'(1);
        if (sel >= DW'(CLIENTS)) sel = sel - DW'(CLIENTS);
        idx   = CLIENTS_W'(sel);
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Burst round-robin arbiter: one client owns the resource until last beat,
// request drop, or the MAX_HOLD beat limit; handover is back-to-back.
import burst_arb_pkg::*;

module burst_rr_arbiter #(
  parameter int CLIENTS   = 8,
  parameter int MAX_HOLD  = 16,
  parameter int CLIENTS_W = $clog2(CLIENTS),
  parameter int HOLD_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CLIENTS-1:0]   request,
  input  logic [CLIENTS-1:0]   last,
  input  logic                 stall,
  output logic [CLIENTS-1:0]   grant,
  output logic                 grant_valid,
  output logic [CLIENTS_W-1:0] grant_id,
  output logic [HOLD_W-1:0]    beat_count,
  output logic                 timeout
);

  arb_state_t           state;
  logic [CLIENTS_W-1:0] ptr;

  logic                 pick_valid;
  logic [CLIENTS_W-1:0] pick_idx;
  logic [CLIENTS-1:0]   pick_onehot;

  logic owner_req;
  logic owner_last;
  logic beat;
  logic at_limit;
  logic rearb;
  logic drop;

  // ptr always equals the current owner, so the owner is searched last.
  rr_pick #(
    .CLIENTS  (CLIENTS),
    .CLIENTS_W(CLIENTS_W)
  ) u_pick (
    .req   (request),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx),
    .onehot(pick_onehot)
  );

  assign owner_req  = |(grant & request);
  assign owner_last = |(grant & last);
  assign beat       = owner_req & ~stall;
  assign at_limit   = (beat_count + HOLD_W'(1)) == HOLD_W'(MAX_HOLD);

  always_comb begin
    rearb = 1'b0;
    drop  = 1'b0;
    case (state)
      ARB_IDLE: rearb = pick_valid & ~stall;
      ARB_OWN: begin
        if (!owner_req) begin
          rearb = pick_valid & ~stall;
          drop  = ~rearb;
        end else if (beat && (owner_last || at_limit)) begin
          rearb = 1'b1;
        end
      end
      default: drop = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      ptr         <= CLIENTS_W'(CLIENTS - 1);
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_count  <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= (state == ARB_OWN) & beat & at_limit & ~owner_last;
      if (rearb) begin
        state       <= ARB_OWN;
        ptr         <= pick_idx;
        grant       <= pick_onehot;
        grant_valid <= 1'b1;
        grant_id    <= pick_idx;
        beat_count  <= '0;
      end else if (drop) begin
        state       <= ARB_IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_id    <= '0;
        beat_count  <= '0;
      end else if (state == ARB_OWN && beat) begin
        beat_count <= beat_count + HOLD_W'(1);
      end
    end
  end

endmodule
